dpram_stream_ctrl: RTL and testbench

Streaming FIFO controller placed in front of the team's dual-port synchronous RAM (`dual_port_sync_ram`, registered read, tri-state `q` outputs). It accepts a valid/ready write stream and drives RAM port A as the write port. It drives RAM port B as a continuous read port and retimes the one-cycle RAM read data into a 2-entry output buffer. The result is a full-throughput valid/ready read stream. The RAM instance stays outside this block; this block owns every RAM control pin.

---
 rtl/dpram_stream_ctrl.sv | 139 +++++++++++++
 tb/tb_dpram_stream_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_stream_ctrl.sv
// dpram_stream_ctrl
// Streaming FIFO controller for an external dual-port synchronous RAM.
// Port A is the write port and takes the valid/ready input stream. Port B
// reads continuously at rd_ptr. The one-cycle registered read data is retimed
// into a 2-entry output buffer, which gives a full-throughput output stream.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Once raised, valid holds with stable data until that transfer.
// in_ready and out_valid never depend combinationally on in_valid or
// out_ready.
//
// A word lives in one of three places: the RAM (r_ram_count), the RAM read
// register (r_rd_pending), or the output buffer (r_ob_count). A read is
// issued only while the buffer has room for everything already in flight, so
// the buffer cannot overflow.

module dpram_stream_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16   // must equal 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH+1:0] level,
    output logic                  ram_cs,
    output logic                  ram_we_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic [DATA_WIDTH-1:0] ram_data_a,
    output logic                  ram_we_b,
    output logic                  ram_oe_b,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    input  logic [DATA_WIDTH-1:0] ram_q_b
);

    localparam logic [ADDR_WIDTH:0] L_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_ram_count;
    logic                  r_rd_pending;
    logic [DATA_WIDTH-1:0] r_ob_mem0;
    logic [DATA_WIDTH-1:0] r_ob_mem1;
    logic                  r_ob_head;
    logic                  r_ob_tail;
    logic [1:0]            r_ob_count;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_issue;
    logic [2:0]            w_in_flight;

    // Handshake and read-credit decode
    always_comb begin
        in_ready    = !rst && (r_ram_count < L_DEPTH);
        w_push      = in_valid && in_ready;
        out_valid   = (r_ob_count != 2'd0);
        out_data    = r_ob_head ? r_ob_mem1 : r_ob_mem0;
        w_pop       = out_valid && out_ready;
        // Words already heading for the buffer; a pop this cycle frees one slot.
        w_in_flight = {1'b0, r_ob_count} + {2'b00, r_rd_pending};
        w_issue     = (r_ram_count != '0) && (w_in_flight < (3'd2 + {2'b00, w_pop}));
    end

    // RAM control pins; port B always reads at rd_ptr
    always_comb begin
        ram_cs     = !rst;
        ram_oe_b   = !rst;
        ram_we_b   = 1'b0;
        ram_we_a   = w_push;
        ram_addr_a = r_wr_ptr;
        ram_data_a = w_push ? in_data : '0;
        ram_addr_b = r_rd_ptr;
    end

    // Total words held anywhere in the controller
    always_comb begin
        level = {1'b0, r_ram_count}
              + {{(ADDR_WIDTH + 1){1'b0}}, r_rd_pending}
              + {{ADDR_WIDTH{1'b0}}, r_ob_count};
    end

    // RAM pointers, RAM occupancy and read-in-flight flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_ram_count  <= '0;
            r_rd_pending <= 1'b0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (w_push)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_rd_pending <= w_issue;
            case ({w_push, w_issue})
                2'b10:   r_ram_count <= r_ram_count + 1'b1;
                2'b01:   r_ram_count <= r_ram_count - 1'b1;
                default: r_ram_count <= r_ram_count;
            endcase
        end
    end

    // Output buffer: capture RAM read data at the tail, pop from the head
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ob_mem0  <= '0;
            r_ob_mem1  <= '0;
            r_ob_head  <= 1'b0;
            r_ob_tail  <= 1'b0;
            r_ob_count <= 2'd0;
        end else begin
            if (r_rd_pending) begin
                if (r_ob_tail) r_ob_mem1 <= ram_q_b;
                else           r_ob_mem0 <= ram_q_b;
                r_ob_tail <= ~r_ob_tail;
            end
            if (w_pop) r_ob_head <= ~r_ob_head;
            case ({r_rd_pending, w_pop})
                2'b10:   r_ob_count <= r_ob_count + 2'd1;
                2'b01:   r_ob_count <= r_ob_count - 2'd1;
                default: r_ob_count <= r_ob_count;
            endcase
        end
    end

    // A capture into a full buffer with no pop means the credit rule is broken
    a_no_ob_overflow: assert property (@(posedge clk) disable iff (rst)
        !(r_rd_pending && !w_pop && (r_ob_count == 2'd2)));

    // The RAM never holds more than DEPTH words
    a_no_ram_overflow: assert property (@(posedge clk) disable iff (rst)
        r_ram_count <= L_DEPTH);

endmodule

// File: tb/tb_dpram_stream_ctrl.sv
// tb_dpram_stream_ctrl
// Drives dpram_stream_ctrl together with a behavioural dual-port RAM. Each
// cycle the outputs are compared against a queue-based model: where every
// word sits (RAM, read in flight, output buffer), plus a data scoreboard.

module tb_dpram_stream_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int DEPTH = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [AW+1:0] level;
    logic          ram_cs, ram_we_a, ram_we_b, ram_oe_b;
    logic [AW-1:0] ram_addr_a, ram_addr_b;
    logic [DW-1:0] ram_data_a;
    logic [DW-1:0] ram_q_b = '0;

    dpram_stream_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level),
        .ram_cs(ram_cs), .ram_we_a(ram_we_a), .ram_addr_a(ram_addr_a),
        .ram_data_a(ram_data_a), .ram_we_b(ram_we_b), .ram_oe_b(ram_oe_b),
        .ram_addr_b(ram_addr_b), .ram_q_b(ram_q_b)
    );

    // Behavioural dual-port RAM with registered read on port B
    logic [DW-1:0] ram_mem [DEPTH];
    always @(posedge clk) begin
        if (ram_cs && ram_we_a) ram_mem[ram_addr_a] <= ram_data_a;
        if (ram_cs && ram_oe_b) ram_q_b <= ram_mem[ram_addr_b];
    end

    // ---------------- model / scoreboard ----------------
    logic [DW-1:0] exp_q[$];     // every accepted word, in order
    logic [DW-1:0] m_ram[$];     // words still in RAM
    logic [DW-1:0] m_buf[$];     // words in the output buffer
    bit            m_pend;
    logic [DW-1:0] m_pend_data;
    int            m_wr_cnt, m_rd_cnt;

    logic [DW-1:0] got_q[$];     // popped words, for the directed tests
    int            pop_cyc[$];
    int            push_cyc[$];
    int            cyc = 0;
    int            n_push = 0;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_ram.delete();
        m_buf.delete();
        exp_q.delete();
        m_pend = 1'b0;
        m_pend_data = '0;
        m_wr_cnt = 0;
        m_rd_cnt = 0;
    endtask

    // One clock cycle: check at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        bit push, pop, issue, exp_rdy, exp_vld;
        int in_flight;
        logic [DW-1:0] d;
        @(negedge clk);
        if (rst) begin
            chk("rst_in_ready", int'(in_ready), 0);
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_out_data", int'(out_data), 0);
            chk("rst_level", int'(level), 0);
            chk("rst_ram_cs", int'(ram_cs), 0);
            chk("rst_ram_we_a", int'(ram_we_a), 0);
            chk("rst_ram_oe_b", int'(ram_oe_b), 0);
            chk("rst_ram_addr_a", int'(ram_addr_a), 0);
            chk("rst_ram_addr_b", int'(ram_addr_b), 0);
            chk("rst_ram_data_a", int'(ram_data_a), 0);
            model_clear();
            @(posedge clk);
            #1;
            cyc++;
            return;
        end
        exp_rdy = (m_ram.size() < DEPTH);
        exp_vld = (m_buf.size() != 0);
        push = in_valid && exp_rdy;
        pop  = out_ready && exp_vld;
        chk("in_ready", int'(in_ready), int'(exp_rdy));
        chk("out_valid", int'(out_valid), int'(exp_vld));
        if (exp_vld) chk("out_data", int'(out_data), int'(m_buf[0]));
        chk("level", int'(level), m_ram.size() + int'(m_pend) + m_buf.size());
        chk("level_le_18", int'(level <= 18), 1);
        chk("ram_cs", int'(ram_cs), 1);
        chk("ram_oe_b", int'(ram_oe_b), 1);
        chk("ram_we_b", int'(ram_we_b), 0);
        chk("ram_we_a", int'(ram_we_a), int'(push));
        if (push) begin
            chk("ram_addr_a", int'(ram_addr_a), m_wr_cnt % DEPTH);
            chk("ram_data_a", int'(ram_data_a), int'(in_data));
        end
        chk("ram_addr_b", int'(ram_addr_b), m_rd_cnt % DEPTH);
        if (pop) begin
            if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
            else begin
                d = exp_q.pop_front();
                chk("sb_data", int'(out_data), int'(d));
            end
            got_q.push_back(out_data);
            pop_cyc.push_back(cyc);
        end
        if (push) begin
            exp_q.push_back(in_data);
            push_cyc.push_back(cyc);
            n_push++;
        end
        in_flight = m_buf.size() + int'(m_pend) - int'(pop);
        issue = (m_ram.size() != 0) && (in_flight < 2);
        @(posedge clk);
        if (pop) void'(m_buf.pop_front());
        if (m_pend) m_buf.push_back(m_pend_data);
        m_pend = issue;
        if (issue) begin
            m_pend_data = m_ram.pop_front();
            m_rd_cnt++;
        end
        if (push) begin
            m_ram.push_back(in_data);
            m_wr_cnt++;
        end
        #1;
        cyc++;
    endtask

    task automatic clear_trace();
        got_q.delete();
        pop_cyc.delete();
        push_cyc.delete();
        n_push = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_clear();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;

        // Three words with the sink always ready
        clear_trace();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h11; cycle();
        in_data = 8'h22; cycle();
        in_data = 8'h33; cycle();
        in_valid = 1'b0;
        repeat (8) cycle();
        chk("t1_pops", got_q.size(), 3);
        if (got_q.size() == 3) begin
            chk("t1_d0", int'(got_q[0]), 8'h11);
            chk("t1_d1", int'(got_q[1]), 8'h22);
            chk("t1_d2", int'(got_q[2]), 8'h33);
            chk("t1_latency", pop_cyc[0] - push_cyc[0], 3);
            chk("t1_back_to_back", pop_cyc[2] - pop_cyc[0], 2);
        end
        chk("t1_level", int'(level), 0);

        // Fill with the sink stalled
        clear_trace();
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data = DW'(i);
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        chk("t2_accepted", n_push, 18);
        chk("t2_in_ready", int'(in_ready), 0);
        chk("t2_level", int'(level), 18);
        out_ready = 1'b1;
        repeat (25) cycle();
        chk("t2_pops", got_q.size(), 18);
        if (got_q.size() == 18)
            for (int i = 0; i < 18; i++) chk("t2_order", int'(got_q[i]), i);
        chk("t2_in_ready_after", int'(in_ready), 1);

        // Sustained streaming across pointer wrap
        clear_trace();
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            in_valid = 1'b1;
            in_data = DW'(8'h40 + i);
            cycle();
        end
        in_valid = 1'b0;
        repeat (6) cycle();
        chk("t3_pushes", n_push, 40);
        chk("t3_pops", got_q.size(), 40);
        if (got_q.size() == 40 && push_cyc.size() == 40) begin
            chk("t3_latency", pop_cyc[0] - push_cyc[0], 3);
            chk("t3_rate", pop_cyc[39] - pop_cyc[0], 39);
            for (int i = 0; i < 40; i++) chk("t3_order", int'(got_q[i]), 8'h40 + i);
        end

        // Random traffic
        for (int i = 0; i < 1000; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data = DW'($urandom_range(0, 255));
            out_ready = ($urandom_range(0, 1) != 0);
            cycle();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (30) cycle();
        chk("t4_drained", int'(level), 0);
        chk("t4_sb_empty", exp_q.size(), 0);

        // Reset in the middle of a stream
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data = DW'(8'hC0 + i);
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        chk("t5_level_before", int'(level), 10);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        clear_trace();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hAB;
        cycle();
        chk("t5_first_push", n_push, 1);
        in_valid = 1'b0;
        repeat (8) cycle();
        chk("t5_pops", got_q.size(), 1);
        if (got_q.size() == 1) chk("t5_data", int'(got_q[0]), 8'hAB);
        chk("t5_level", int'(level), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #200000;
        $display("FAIL timeout: got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
